// File: rtl/seven_segment_decoder.sv
// Seven-segment receiver: synchronizes and debounces a pad pattern, decodes it
// back to a BCD digit and checks that successive digits count 0..9..0.
module seven_segment_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter bit INVERT        = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       seg_in,
  input  logic             clear,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             digit_strobe,
  output logic             invalid,
  output logic             seq_error,
  output logic [CNT_W-1:0] change_count,
  output logic [7:0]       error_count
);

  localparam logic [7:0]       STAB_MAX  = 8'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHG_MAX   = {CNT_W{1'b1}};
  localparam logic [7:0]       ERR_MAX   = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } seq_state_t;

  // Handshake: there is no back-pressure. digit_strobe acts as a valid that is
  // high for exactly one cycle per accepted decimal glyph; the consumer must
  // sample digit_out and the statistics in that cycle.

  logic [6:0] sync1;
  logic [6:0] sync2;
  logic [6:0] s;
  logic [6:0] cand;
  logic [6:0] acc;
  logic [7:0] stab;
  logic       accept;

  seq_state_t state_q;
  seq_state_t state_d;
  logic [3:0] prev_q;
  logic [3:0] prev_d;

  logic             is_glyph;
  logic             is_blank;
  logic [3:0]       glyph_digit;
  logic [3:0]       expect_digit;

  logic [3:0]       digit_d;
  logic             valid_d;
  logic             strobe_d;
  logic             invalid_d;
  logic             seq_error_d;
  logic [CNT_W-1:0] change_d;
  logic [7:0]       error_d;

  assign s      = INVERT ? ~sync2 : sync2;
  assign accept = (stab == STAB_MAX) && (cand != acc);

  // Input synchronizer and stability filter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      stab  <= '0;
      acc   <= '0;
    end else begin
      sync1 <= seg_in;
      sync2 <= sync1;
      if (s != cand) begin
        cand <= s;
        stab <= '0;
      end else if (stab < STAB_MAX) begin
        stab <= stab + 8'd1;
      end
      if (accept) begin
        acc <= cand;
      end
    end
  end

  // Glyph decode of the candidate being accepted; 0x27 is deliberately not a 7.
  always_comb begin
    is_glyph    = 1'b1;
    glyph_digit = 4'd0;
    case (cand)
      7'h3F:   glyph_digit = 4'd0;
      7'h06:   glyph_digit = 4'd1;
      7'h5B:   glyph_digit = 4'd2;
      7'h4F:   glyph_digit = 4'd3;
      7'h66:   glyph_digit = 4'd4;
      7'h6D:   glyph_digit = 4'd5;
      7'h7D:   glyph_digit = 4'd6;
      7'h07:   glyph_digit = 4'd7;
      7'h7F:   glyph_digit = 4'd8;
      7'h6F:   glyph_digit = 4'd9;
      default: is_glyph    = 1'b0;
    endcase
  end

  assign is_blank     = (cand == 7'h00);
  assign expect_digit = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;

  // Sequence FSM and output next-state.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    digit_d     = digit_out;
    valid_d     = digit_valid;
    strobe_d    = 1'b0;
    invalid_d   = invalid;
    seq_error_d = seq_error;
    change_d    = change_count;
    error_d     = error_count;

    if (accept) begin
      if (is_glyph) begin
        digit_d   = glyph_digit;
        valid_d   = 1'b1;
        invalid_d = 1'b0;
        strobe_d  = 1'b1;
        if (change_count != CHG_MAX) begin
          change_d = change_count + CNT_W'(1);
        end
        if ((state_q == TRACK) && (glyph_digit != expect_digit)) begin
          seq_error_d = 1'b1;
          if (error_count != ERR_MAX) begin
            error_d = error_count + 8'd1;
          end
        end
        prev_d  = glyph_digit;
        state_d = TRACK;
      end else if (is_blank) begin
        valid_d   = 1'b0;
        invalid_d = 1'b0;
        state_d   = IDLE;
      end else begin
        valid_d   = 1'b0;
        invalid_d = 1'b1;
        if (error_count != ERR_MAX) begin
          error_d = error_count + 8'd1;
        end
        state_d = IDLE;
      end
    end

    // Clear wins over any coincident count or FSM update, but not the display.
    if (clear) begin
      change_d    = '0;
      error_d     = '0;
      seq_error_d = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      digit_out    <= '0;
      digit_valid  <= 1'b0;
      digit_strobe <= 1'b0;
      invalid      <= 1'b0;
      seq_error    <= 1'b0;
      change_count <= '0;
      error_count  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      digit_out    <= digit_d;
      digit_valid  <= valid_d;
      digit_strobe <= strobe_d;
      invalid      <= invalid_d;
      seq_error    <= seq_error_d;
      change_count <= change_d;
      error_count  <= error_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: scoreboard on digit_strobe for the default
// instance, directed checks for flags, clear, reset and an inverted instance.
module tb_seven_segment_decoder;

  localparam int W = 29;  // {seq_error, error_count[7:0], change_count[15:0], digit[3:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Default instance
  logic        reset_n;
  logic [6:0]  seg_in;
  logic        clear;
  logic [3:0]  digit_out;
  logic        digit_valid, digit_strobe, invalid, seq_error;
  logic [15:0] change_count;
  logic [7:0]  error_count;

  // Inverted, single-cycle filter instance
  logic        reset_n2;
  logic [6:0]  seg_in2;
  logic        clear2;
  logic [3:0]  digit_out2;
  logic        digit_valid2, digit_strobe2, invalid2, seq_error2;
  logic [15:0] change_count2;
  logic [7:0]  error_count2;

  seven_segment_decoder #(.STABLE_CYCLES(4), .CNT_W(16), .INVERT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .clear(clear),
    .digit_out(digit_out), .digit_valid(digit_valid), .digit_strobe(digit_strobe),
    .invalid(invalid), .seq_error(seq_error), .change_count(change_count),
    .error_count(error_count)
  );

  seven_segment_decoder #(.STABLE_CYCLES(1), .CNT_W(16), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset_n(reset_n2), .seg_in(seg_in2), .clear(clear2),
    .digit_out(digit_out2), .digit_valid(digit_valid2), .digit_strobe(digit_strobe2),
    .invalid(invalid2), .seq_error(seq_error2), .change_count(change_count2),
    .error_count(error_count2)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic seq, input logic [7:0] err,
                                      input logic [15:0] cc, input logic [3:0] d);
    return {seq, err, cc, d};
  endfunction

  // Monitor: every strobe must match the oldest expected acceptance.
  always @(negedge clk) begin
    if (reset_n && digit_strobe) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sb_digit",        digit_out,    e[3:0]);
        check("sb_change_count", change_count, e[19:4]);
        check("sb_error_count",  error_count,  e[27:20]);
        check("sb_seq_error",    seq_error,    e[28]);
      end
    end
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic hold1(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold2(input logic [6:0] p, input int n);
    seg_in2 = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_reset_values1();
    check("rst_digit_out",    digit_out,    0);
    check("rst_digit_valid",  digit_valid,  0);
    check("rst_digit_strobe", digit_strobe, 0);
    check("rst_invalid",      invalid,      0);
    check("rst_seq_error",    seq_error,    0);
    check("rst_change_count", change_count, 0);
    check("rst_error_count",  error_count,  0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [6:0] glyphs [10];
  int lat;

  initial begin
    glyphs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    reset_n = 1'b0; seg_in = 7'h00; clear = 1'b0;
    reset_n2 = 1'b0; seg_in2 = 7'h00; clear2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values1();
    reset_n = 1'b1;
    hold1(7'h00, 10);
    check("blank_after_reset_no_event", change_count, 0);

    // Single digit 1: latency of 7 edges, unchecked in IDLE.
    exp_q.push_back(mk(1'b0, 8'd0, 16'd1, 4'd1));
    seg_in = 7'h06;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (digit_strobe && lat == 0) lat = i;
    end
    check("latency_edges", lat, 7);
    check("t1_digit_out", digit_out, 1);
    check("t1_change_count", change_count, 1);

    // Full 0..9..0 run including the 9->0 wrap.
    pulse_clear();
    for (int k = 0; k <= 10; k++) begin
      exp_q.push_back(mk(1'b0, 8'd0, 16'(k + 1), 4'(k % 10)));
      hold1(glyphs[k % 10], 8);
    end
    check("t2_digit_out", digit_out, 0);
    check("t2_change_count", change_count, 11);
    check("t2_seq_error", seq_error, 0);

    // 3-cycle glitch to 8 on a steady 3 must be filtered out.
    pulse_clear();
    exp_q.push_back(mk(1'b0, 8'd0, 16'd1, 4'd3));
    hold1(7'h4F, 8);
    hold1(7'h7F, 3);
    hold1(7'h4F, 10);
    check("t3_digit_out", digit_out, 3);
    check("t3_change_count", change_count, 1);

    // 2,3,5 -> sequence error; 0x27 -> invalid; 6 unchecked from IDLE.
    pulse_clear();
    exp_q.push_back(mk(1'b0, 8'd0, 16'd1, 4'd2));
    hold1(7'h5B, 8);
    exp_q.push_back(mk(1'b0, 8'd0, 16'd2, 4'd3));
    hold1(7'h4F, 8);
    exp_q.push_back(mk(1'b1, 8'd1, 16'd3, 4'd5));
    hold1(7'h6D, 8);
    hold1(7'h27, 8);
    check("t4_invalid", invalid, 1);
    check("t4_digit_valid_inv", digit_valid, 0);
    check("t4_error_count_inv", error_count, 2);
    check("t4_digit_out_hold", digit_out, 5);
    exp_q.push_back(mk(1'b1, 8'd2, 16'd4, 4'd6));
    hold1(7'h7D, 8);
    check("t4_invalid_cleared", invalid, 0);
    check("t4_seq_error_sticky", seq_error, 1);

    // 4, blank, 7 with clear on the acceptance edge, then 9 (no error: IDLE).
    pulse_clear();
    exp_q.push_back(mk(1'b0, 8'd0, 16'd1, 4'd4));
    hold1(7'h66, 8);
    hold1(7'h00, 8);
    check("t5_blank_digit_valid", digit_valid, 0);
    check("t5_blank_invalid", invalid, 0);
    check("t5_blank_digit_out", digit_out, 4);
    check("t5_blank_error_count", error_count, 0);
    exp_q.push_back(mk(1'b0, 8'd0, 16'd0, 4'd7));
    seg_in = 7'h07;
    repeat (6) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("t5_clear_strobe", digit_strobe, 1);
    check("t5_clear_digit_out", digit_out, 7);
    hold1(7'h07, 1);
    exp_q.push_back(mk(1'b0, 8'd0, 16'd1, 4'd9));
    hold1(7'h6F, 8);
    check("t5_after_clear_seq_error", seq_error, 0);

    // Reset mid-filter discards the pending candidate.
    hold1(7'h3F, 4);
    reset_n = 1'b0;
    seg_in = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values1();
    reset_n = 1'b1;
    hold1(7'h00, 12);
    check("t6_post_reset_valid", digit_valid, 0);
    check("t6_post_reset_count", change_count, 0);
    check("sb_queue_empty", exp_q.size(), 0);

    // Inverted instance: pad 00 reads as 8; then saturate error_count.
    repeat (2) @(posedge clk);
    #1;
    reset_n2 = 1'b1;
    hold2(7'h00, 6);
    check("inv_digit_out", digit_out2, 8);
    check("inv_digit_valid", digit_valid2, 1);
    check("inv_change_count", change_count2, 1);
    for (int i = 0; i < 255; i++) begin
      hold2(7'h58, 5);
      hold2(7'h00, 5);
    end
    check("inv_error_count_255", error_count2, 255);
    check("inv_change_count_256", change_count2, 256);
    hold2(7'h58, 5);
    check("inv_error_count_sat", error_count2, 255);
    check("inv_invalid", invalid2, 1);
    check("inv_digit_out_hold", digit_out2, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
